ball_physics: RTL

Parametrised ball-motion engine for one side of the two-board pong game. It owns the ball while the ball is on this board: serving, wall bounces, paddle collision with speed-up and spin, and miss detection. It hands the ball to the opponent through a valid/ready channel that feeds the communication sender, and accepts incoming balls from the receiver. The display logic consumes its position outputs, and its `frame_tick` input is driven from the display's end-of-frame pulse.

---
 rtl/ball_physics_if.sv | 26 ++
 rtl/ball_physics.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ball_physics_if.sv
// Ball hand-off link: outgoing ball to the comms sender, incoming ball from the receiver.
// The physics engine is the master side, the comms block the slave side.
interface ball_physics_if #(
    parameter int VEL_W = 4
);
    logic             rx_valid;
    logic             rx_ready;
    logic [8:0]       rx_ball_y;
    logic [VEL_W-1:0] rx_vx;
    logic [VEL_W-1:0] rx_vy;
    logic             tx_valid;
    logic             tx_ready;
    logic [8:0]       tx_ball_y;
    logic [VEL_W-1:0] tx_vx;
    logic [VEL_W-1:0] tx_vy;

    modport master (
        input  rx_valid, rx_ball_y, rx_vx, rx_vy, tx_ready,
        output rx_ready, tx_valid, tx_ball_y, tx_vx, tx_vy
    );

    modport slave (
        output rx_valid, rx_ball_y, rx_vx, rx_vy, tx_ready,
        input  rx_ready, tx_valid, tx_ball_y, tx_vx, tx_vy
    );
endinterface

// File: rtl/ball_physics.sv
// Ball-motion engine for one board of two-board pong: serve, wall bounce,
// paddle hit with speed-up and spin, miss detection and net hand-off.
module ball_physics #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_SIZE   = 5,
    parameter int PADDLE_X    = 16,
    parameter int PADDLE_W    = 4,
    parameter int PADDLE_H    = 48,
    parameter int VEL_W       = 4,
    parameter int MAX_VX      = 7,
    parameter int SERVE_VX    = 2,
    parameter int START_SERVE = 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           frame_tick,
    input  logic [9:0]     paddle_y,
    input  logic           serve,
    input  logic           serve_grant,
    ball_physics_if.master link,
    output logic           miss,
    output logic [9:0]     ball_left,
    output logic [9:0]     ball_top,
    output logic           ball_visible,
    output logic [1:0]     state
);
    typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, HANDOFF = 2'd3} state_t;
    typedef logic signed [11:0]    s12_t;
    typedef logic signed [VEL_W:0] vx_t;   // one extra bit so a full-range rx magnitude can be negated
    typedef logic signed [VEL_W-1:0] vy_t;

    localparam s12_t   ZERO      = '0;
    localparam s12_t   ONE       = s12_t'(1);
    localparam s12_t   FACE      = s12_t'(PADDLE_X + PADDLE_W);
    localparam s12_t   Y_MAX     = s12_t'(SCREEN_H - BALL_SIZE);
    localparam s12_t   NET       = s12_t'(SCREEN_W);
    localparam s12_t   B_SIZE    = s12_t'(BALL_SIZE);
    localparam s12_t   B_HALF    = s12_t'(BALL_SIZE / 2);
    localparam s12_t   P_H       = s12_t'(PADDLE_H);
    localparam s12_t   THIRD     = s12_t'(PADDLE_H / 3);
    localparam s12_t   TWO_THIRD = s12_t'(2 * PADDLE_H / 3);
    localparam s12_t   SERVE_OFS = s12_t'(PADDLE_H / 2 - BALL_SIZE / 2);
    localparam s12_t   VX_CEIL   = s12_t'(MAX_VX);
    localparam s12_t   VY_LIM    = s12_t'(2 ** (VEL_W - 1) - 1);
    localparam state_t RESET_ST  = (START_SERVE != 0) ? SERVE : IDLE;

    state_t           state_q, state_d;
    vx_t              vx;
    vy_t              vy;
    logic [8:0]       tx_ball_y_q;
    logic [VEL_W-1:0] tx_vx_q, tx_vy_q;

    s12_t px, top_s, py, nx, ny, ny_clamp, vy_b, vy_s, vy_sat, off, vx_hit;
    s12_t rx_mag, rx_top, serve_top;
    logic going_left, in_window, overlap, hit, missed, at_net;

    // Motion arithmetic for the current tick, all in signed 12 bits.
    // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
    always_comb begin
        px         = s12_t'(ball_left);
        top_s      = s12_t'(ball_top);
        py         = s12_t'(paddle_y);
        nx         = px + s12_t'(vx);
        ny         = top_s + s12_t'(vy);
        ny_clamp   = ny;
        vy_b       = s12_t'(vy);
        if (ny <= ZERO) begin
            ny_clamp = ZERO;
            vy_b     = -s12_t'(vy);
        end else if (ny >= Y_MAX) begin
            ny_clamp = Y_MAX;
            vy_b     = -s12_t'(vy);
        end

        going_left = vx[VEL_W];
        in_window  = going_left && (px >= FACE) && (nx <= FACE);
        overlap    = (top_s + B_SIZE > py) && (top_s < py + P_H);
        hit        = in_window && overlap;
        off        = top_s + B_HALF - py;
        vy_s       = vy_b;
        if (hit) begin
            if (off < THIRD)           vy_s = vy_b - ONE;
            else if (off >= TWO_THIRD) vy_s = vy_b + ONE;
        end
        vy_sat     = vy_s;
        if (vy_s > VY_LIM)       vy_sat = VY_LIM;
        else if (vy_s < -VY_LIM) vy_sat = -VY_LIM;

        vx_hit     = -s12_t'(vx) + ONE;
        if (vx_hit > VX_CEIL) vx_hit = VX_CEIL;
        missed     = going_left && (nx <= ZERO) && !hit;
        at_net     = !going_left && (vx != '0) && (nx + B_SIZE >= NET);

        rx_mag     = (link.rx_vx == '0) ? ONE : s12_t'(link.rx_vx);
        rx_top     = (s12_t'(link.rx_ball_y) > Y_MAX) ? Y_MAX : s12_t'(link.rx_ball_y);
        serve_top  = py + SERVE_OFS;
        if (serve_top > Y_MAX)     serve_top = Y_MAX;
        else if (serve_top < ZERO) serve_top = ZERO;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (link.rx_valid) state_d = PLAY;
                     else if (serve_grant) state_d = SERVE;
            SERVE:   if (serve) state_d = PLAY;
            PLAY:    if (frame_tick && !hit) begin
                         if (missed)      state_d = IDLE;
                         else if (at_net) state_d = HANDOFF;
                     end
            HANDOFF: if (link.tx_ready) state_d = IDLE;
        endcase
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clock) begin
        if (reset) state_q <= RESET_ST;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ball_left    <= 10'(FACE);
            ball_top     <= 10'(SCREEN_H / 2);
            vx           <= '0;
            vy           <= '0;
            miss         <= 1'b0;
            ball_visible <= (RESET_ST == SERVE);
            tx_ball_y_q  <= '0;
            tx_vx_q      <= '0;
            tx_vy_q      <= '0;
        end else begin
            miss         <= 1'b0;
            ball_visible <= (state_d == SERVE) || (state_d == PLAY);
            unique case (state_q)
                IDLE: if (link.rx_valid) begin
                    ball_left <= 10'(SCREEN_W - BALL_SIZE);
                    ball_top  <= 10'(rx_top);
                    vx        <= vx_t'(-rx_mag);
                    vy        <= link.rx_vy;
                end
                SERVE: begin
                    ball_left <= 10'(FACE);
                    ball_top  <= 10'(serve_top);
                    if (serve) begin
                        vx <= vx_t'(SERVE_VX);
                        vy <= vy_t'(1);
                    end
                end
                PLAY: if (frame_tick) begin
                    // Y bounce always applies, even on a hit, miss or net tick.
                    ball_top <= 10'(ny_clamp);
                    vy       <= vy_t'(vy_sat);
                    if (hit) begin
                        ball_left <= 10'(FACE);
                        vx        <= vx_t'(vx_hit);
                    end else if (missed) begin
                        miss <= 1'b1;
                    end else if (at_net) begin
                        tx_ball_y_q <= ball_top[8:0];
                        tx_vx_q     <= vx[VEL_W-1:0];
                        tx_vy_q     <= vy_t'(vy_sat);
                    end else begin
                        ball_left <= 10'(nx);
                    end
                end
                HANDOFF: ;
            endcase
        end
    end

    assign state          = state_q;
    assign link.rx_ready  = (state_q == IDLE);
    assign link.tx_valid  = (state_q == HANDOFF);
    assign link.tx_ball_y = tx_ball_y_q;
    assign link.tx_vx     = tx_vx_q;
    assign link.tx_vy     = tx_vy_q;
endmodule
